// File: rtl/sobel_window_controller.sv
// Raster-stream front end for the Sobel datapath: two line buffers plus a 3x3 shift window, one pulse per interior pixel.
// Window and pulse register on the accept edge. pixel_ready_o is high only while a frame is running, so there are no stall bubbles.
module sobel_window_controller #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COORD_W    = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               frame_start_i,
  input  logic               pixel_valid_i,
  input  logic [7:0]         pixel_data_i,
  output logic               pixel_ready_o,
  output logic [7:0]         window_buffer_o [0:8],
  output logic               start_calculations_o,
  output logic [COORD_W-1:0] window_row_o,
  output logic [COORD_W-1:0] window_col_o,
  output logic               frame_done_o
);

  localparam int IDX_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q;
  logic               pixel_ready_q;
  logic               start_q;
  logic               done_q;
  logic [COORD_W-1:0] row_q, col_q, row_d, col_d;
  logic [COORD_W-1:0] wrow_q, wcol_q;
  logic [7:0]         win_q [0:8];
  logic [7:0]         lb0_q [0:IMG_WIDTH-1];
  logic [7:0]         lb1_q [0:IMG_WIDTH-1];

  logic               accept;
  logic               last_col, last_row, win_ok;
  logic [IDX_W-1:0]   cidx;
  logic [7:0]         top_dat, mid_dat;

  assign cidx = col_q[IDX_W-1:0];

  always_comb begin
    accept   = pixel_valid_i & pixel_ready_q;
    last_col = (col_q == COORD_W'(IMG_WIDTH - 1));
    last_row = (row_q == COORD_W'(IMG_HEIGHT - 1));
    win_ok   = (row_q >= COORD_W'(2)) && (col_q >= COORD_W'(2));
    top_dat  = lb1_q[cidx];
    mid_dat  = lb0_q[cidx];
    col_d    = last_col ? '0 : col_q + COORD_W'(1);
    row_d    = last_col ? row_q + COORD_W'(1) : row_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      pixel_ready_q <= 1'b0;
      start_q       <= 1'b0;
      done_q        <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
      wrow_q        <= '0;
      wcol_q        <= '0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_start_i) begin
            state_q       <= RUN;
            pixel_ready_q <= 1'b1;
            row_q         <= '0;
            col_q         <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            col_q <= col_d;
            row_q <= row_d;
            for (int i = 0; i < 3; i++) begin
              win_q[3*i]   <= win_q[3*i+1];
              win_q[3*i+1] <= win_q[3*i+2];
            end
            win_q[2] <= top_dat;
            win_q[5] <= mid_dat;
            win_q[8] <= pixel_data_i;
            if (win_ok) begin
              start_q <= 1'b1;
              wrow_q  <= row_q - COORD_W'(1);
              wcol_q  <= col_q - COORD_W'(1);
            end
            if (last_col && last_row) begin
              state_q       <= DONE;
              pixel_ready_q <= 1'b0;
              done_q        <= 1'b1;
              row_q         <= '0;
              col_q         <= '0;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line buffers are never cleared: rows 0 and 1 refill them before any window reads them.
  always_ff @(posedge clk_i) begin
    if (accept && !rst_i) begin
      lb1_q[cidx] <= mid_dat;
      lb0_q[cidx] <= pixel_data_i;
    end
  end

  assign pixel_ready_o        = pixel_ready_q;
  assign window_buffer_o      = win_q;
  assign start_calculations_o = start_q;
  assign window_row_o         = wrow_q;
  assign window_col_o         = wcol_q;
  assign frame_done_o         = done_q;

endmodule
